// File: rtl/signed_mag_comparator.sv
// Sign-magnitude comparator: combinational one-hot result {aLTb, aGTb, aEQb}
// plus a one-cycle registered copy that an async active-low reset clears to all-zero.
module signed_mag_comparator #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             aLTb,
    output logic             aGTb,
    output logic             aEQb,
    output logic             aLTb_q,
    output logic             aGTb_q,
    output logic             aEQb_q
);

    logic [WIDTH-2:0] ma;
    logic [WIDTH-2:0] mb;
    logic             za;
    logic             zb;
    logic             ea;
    logic             eb;
    logic             mag_lt;
    logic             mag_gt;

    // Decode both operands; negative zero collapses onto positive zero.
    always_comb begin
        ma     = a[WIDTH-2:0];
        mb     = b[WIDTH-2:0];
        za     = (ma == '0);
        zb     = (mb == '0);
        ea     = a[WIDTH-1] & ~za;
        eb     = b[WIDTH-1] & ~zb;
        mag_lt = (ma < mb);
        mag_gt = (ma > mb);
    end

    // Rule-ordered compare; negative pairs invert the magnitude ordering.
    always_comb begin
        aLTb = 1'b0;
        aGTb = 1'b0;
        aEQb = 1'b0;
        if (za && zb) begin
            aEQb = 1'b1;
        end else if (!ea && eb) begin
            aGTb = 1'b1;
        end else if (ea && !eb) begin
            aLTb = 1'b1;
        end else if (!ea) begin
            aLTb = mag_lt;
            aGTb = mag_gt;
            aEQb = ~mag_lt & ~mag_gt;
        end else begin
            aLTb = mag_gt;
            aGTb = mag_lt;
            aEQb = ~mag_lt & ~mag_gt;
        end
    end

    // Register the result; reset yields the only non-one-hot state (all zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aLTb_q <= 1'b0;
            aGTb_q <= 1'b0;
            aEQb_q <= 1'b0;
        end else begin
            aLTb_q <= aLTb;
            aGTb_q <= aGTb;
            aEQb_q <= aEQb;
        end
    end

endmodule

// File: tb/tb_signed_mag_comparator.sv
// Self-checking bench for signed_mag_comparator: directed cases, exhaustive sweep with a
// mid-sweep async reset, and random pairs, all checked against an integer-valued model.
module tb_signed_mag_comparator;

    localparam int W = 7;
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         aLTb;
    logic         aGTb;
    logic         aEQb;
    logic         aLTb_q;
    logic         aGTb_q;
    logic         aEQb_q;

    int vectors;
    int miscompares;

    signed_mag_comparator #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .aLTb   (aLTb),
        .aGTb   (aGTb),
        .aEQb   (aEQb),
        .aLTb_q (aLTb_q),
        .aGTb_q (aGTb_q),
        .aEQb_q (aEQb_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: map each operand to its signed integer value and compare numerically.
    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] xv;
        logic [W-1:0] yv;
        int           ix;
        int           iy;
        xv = x;
        yv = y;
        ix = int'(xv[W-2:0]);
        iy = int'(yv[W-2:0]);
        if (xv[W-1]) ix = -ix;
        if (yv[W-1]) iy = -iy;
        if (ix < iy) return LT;
        if (ix > iy) return GT;
        return EQ;
    endfunction

    function automatic logic [2:0] comb_out();
        return {aLTb, aGTb, aEQb};
    endfunction

    function automatic logic [2:0] reg_out();
        return {aLTb_q, aGTb_q, aEQb_q};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a = 7'b0000001;
        b = 7'b0000000;
        #1;
        vectors++;
        if (reg_out() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_q_async got=%b exp=000", reg_out());
        end
        vectors++;
        if (comb_out() !== GT) begin
            miscompares++;
            $display("FAIL reset_comb got=%b exp=%b", comb_out(), GT);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (reg_out() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_q_held got=%b exp=000", reg_out());
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (reg_out() !== GT) begin
            miscompares++;
            $display("FAIL reset_release_q got=%b exp=%b", reg_out(), GT);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic [2:0]   te [8];
        ta[0] = 7'b0000011; tb[0] = 7'b1000101; te[0] = GT;
        ta[1] = 7'b1000101; tb[1] = 7'b0000011; te[1] = LT;
        ta[2] = 7'b1000000; tb[2] = 7'b0000000; te[2] = EQ;
        ta[3] = 7'b1000000; tb[3] = 7'b1000000; te[3] = EQ;
        ta[4] = 7'b1000011; tb[4] = 7'b1000101; te[4] = GT;
        ta[5] = 7'b0111111; tb[5] = 7'b1111111; te[5] = GT;
        ta[6] = 7'b1000000; tb[6] = 7'b0000001; te[6] = LT;
        ta[7] = 7'b1111111; tb[7] = 7'b1111110; te[7] = LT;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            a = ta[i];
            b = tb[i];
            @(negedge clk);
            vectors++;
            if (comb_out() !== te[i]) begin
                miscompares++;
                $display("FAIL directed_comb[%0d] a=%b b=%b got=%b exp=%b",
                         i, ta[i], tb[i], comb_out(), te[i]);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (reg_out() !== te[i]) begin
                miscompares++;
                $display("FAIL directed_q[%0d] got=%b exp=%b", i, reg_out(), te[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [2:0] exp;
        logic [2:0] prev;
        logic       have_prev;
        bit         rst_cycle;
        have_prev = 1'b0;
        prev = 3'b000;
        for (int i = 0; i < 128 * 128; i++) begin
            @(posedge clk);
            #1;
            a = W'(i / 128);
            b = W'(i % 128);
            exp = model(a, b);
            rst_cycle = (i == 5000);
            if (rst_cycle) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if (reg_out() !== 3'b000) begin
                    miscompares++;
                    $display("FAIL sweep_async_reset got=%b exp=000", reg_out());
                end
            end
            @(negedge clk);
            vectors++;
            if (comb_out() !== exp) begin
                miscompares++;
                $display("FAIL sweep_comb a=%b b=%b got=%b exp=%b", a, b, comb_out(), exp);
            end
            vectors++;
            if ($countones(comb_out()) != 1) begin
                miscompares++;
                $display("FAIL sweep_onehot a=%b b=%b got=%b exp=one-hot", a, b, comb_out());
            end
            if (rst_cycle) begin
                vectors++;
                if (reg_out() !== 3'b000) begin
                    miscompares++;
                    $display("FAIL sweep_reset_held got=%b exp=000", reg_out());
                end
                rst_n = 1'b1;
            end else if (have_prev) begin
                vectors++;
                if (reg_out() !== prev) begin
                    miscompares++;
                    $display("FAIL sweep_q a=%b b=%b got=%b exp=%b", a, b, reg_out(), prev);
                end
            end
            prev = exp;
            have_prev = 1'b1;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   fwd;
        for (int i = 0; i < 200; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            @(posedge clk);
            #1;
            a = x;
            b = y;
            @(negedge clk);
            fwd = comb_out();
            vectors++;
            if (fwd !== model(x, y)) begin
                miscompares++;
                $display("FAIL random_comb a=%b b=%b got=%b exp=%b", x, y, fwd, model(x, y));
            end
            a = y;
            b = x;
            #1;
            vectors++;
            if (comb_out() !== {fwd[1], fwd[2], fwd[0]}) begin
                miscompares++;
                $display("FAIL random_symmetry a=%b b=%b got=%b exp=%b",
                         y, x, comb_out(), {fwd[1], fwd[2], fwd[0]});
            end
        end
    endtask

    task automatic test_equal_nonzero();
        @(posedge clk);
        #1;
        a = 7'b1010101;
        b = 7'b1010101;
        @(negedge clk);
        vectors++;
        if (comb_out() !== EQ) begin
            miscompares++;
            $display("FAIL equal_nonzero_comb got=%b exp=%b", comb_out(), EQ);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (reg_out() !== EQ) begin
            miscompares++;
            $display("FAIL equal_nonzero_q got=%b exp=%b", reg_out(), EQ);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_equal_nonzero();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
